// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: edge driver for the systolic MAC array.
// Takes one column vector per cycle and drives each array row with a
// row-dependent delay. Row k lags row 0 by k cycles, which forms the diagonal
// wavefront. Tiles are tracked as they pass through, and after the last beat
// of a tile the input is held off until that beat has left the deepest lane.

// One skew lane: a DEPTH-stage register chain carrying {data, valid}.
module systolic_skew_lane #(
    parameter int DEPTH      = 1,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid
);
    logic [DEPTH-1:0][DATA_WIDTH-1:0] r_data;
    logic [DEPTH-1:0]                 r_vld_pipe;

    // Shift {data, valid} one stage per cycle. Stage 0 loads every cycle, so a
    // cycle with no accept enters the chain as a valid=0 bubble.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_data     <= '0;
            r_vld_pipe <= '0;
        end else begin
            r_data[0]     <= i_data;
            r_vld_pipe[0] <= i_valid;
            for (int s = 1; s < DEPTH; s++) begin
                r_data[s]     <= r_data[s-1];
                r_vld_pipe[s] <= r_vld_pipe[s-1];
            end
        end
    end

    assign o_data  = r_data[DEPTH-1];
    assign o_valid = r_vld_pipe[DEPTH-1];
endmodule

module systolic_skew_feeder #(
    parameter int N_LANES    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BEATS  = 256
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [N_LANES*DATA_WIDTH-1:0]   s_data_i,
    input  logic                            s_valid_i,
    input  logic                            s_last_i,
    output logic                            s_ready_o,
    output logic [N_LANES*DATA_WIDTH-1:0]   lane_data_o,
    output logic [N_LANES-1:0]              lane_valid_o,
    output logic                            busy_o,
    output logic                            tile_done_o,
    output logic [$clog2(MAX_BEATS+1)-1:0]  beat_count_o,
    output logic                            overflow_o
);
    localparam int CW  = $clog2(MAX_BEATS+1);
    localparam int DCW = (N_LANES > 1) ? $clog2(N_LANES) : 1;
    localparam logic [DCW-1:0] DRAIN_INIT = DCW'(N_LANES-1);
    localparam logic [CW-1:0]  BEAT_MAX   = CW'(MAX_BEATS);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [DCW-1:0] r_drain;
    logic [CW-1:0]  r_beat_cnt;
    logic           r_overflow;
    logic           w_accept;
    logic           w_drain_end;

    assign s_ready_o    = (r_state != DRAIN);
    assign busy_o       = (r_state != IDLE);
    assign w_accept     = s_valid_i & s_ready_o;
    assign w_drain_end  = (r_state == DRAIN) && (r_drain == '0);
    assign tile_done_o  = w_drain_end;
    assign beat_count_o = r_beat_cnt;
    assign overflow_o   = r_overflow;

    // Every lane sees the same accept strobe. Lane k has k+1 stages, so lane k
    // lags lane 0 by k cycles.
    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        systolic_skew_lane #(
            .DEPTH      (k + 1),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_lane (
            .i_clk   (clk_i),
            .i_rst   (rst_i),
            .i_data  (s_data_i[k*DATA_WIDTH +: DATA_WIDTH]),
            .i_valid (w_accept),
            .o_data  (lane_data_o[k*DATA_WIDTH +: DATA_WIDTH]),
            .o_valid (lane_valid_o[k])
        );
    end

    // Next-state logic. DRAIN blocks input until the final beat of the tile
    // has reached lane N_LANES-1.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = s_last_i ? DRAIN : STREAM;
            STREAM:  if (w_accept && s_last_i) w_state_nxt = DRAIN;
            DRAIN:   if (w_drain_end) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Drain countdown. It loads on entry to DRAIN, so tile_done lines up with
    // the last beat appearing on the deepest lane.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_drain <= '0;
        else if (r_state != DRAIN && w_state_nxt == DRAIN)
            r_drain <= DRAIN_INIT;
        else if (r_state == DRAIN && !w_drain_end)
            r_drain <= r_drain - DCW'(1);
    end

    // Beat counter and sticky overflow. Both restart on a tile's first accept
    // and otherwise hold their values, so the result stays readable after done.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_beat_cnt <= '0;
            r_overflow <= 1'b0;
        end else if (w_accept) begin
            if (r_state == IDLE) begin
                r_beat_cnt <= CW'(1);
                r_overflow <= 1'b0;
            end else if (r_beat_cnt == BEAT_MAX) begin
                r_overflow <= 1'b1;
            end else begin
                r_beat_cnt <= r_beat_cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder. The reference model keeps a
// per-cycle history of accepted beats and last flags. From that history it
// derives the expected lane outputs, ready, done and beat accounting using the
// timing rules: lane k at t+1+k, ready low for N cycles after a last beat, and
// done N cycles after the last beat.
module tb_systolic_skew_feeder;
    localparam int N    = 4;
    localparam int W    = 16;
    localparam int MB   = 4;
    localparam int CW   = $clog2(MB+1);
    localparam int HMAX = 4096;

    logic             clk = 1'b0;
    logic             rst;
    logic [N*W-1:0]   s_data;
    logic             s_valid;
    logic             s_last;
    logic             s_ready;
    logic [N*W-1:0]   lane_data;
    logic [N-1:0]     lane_valid;
    logic             busy;
    logic             tile_done;
    logic [CW-1:0]    beat_count;
    logic             overflow;

    systolic_skew_feeder #(.N_LANES(N), .DATA_WIDTH(W), .MAX_BEATS(MB)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .s_data_i     (s_data),
        .s_valid_i    (s_valid),
        .s_last_i     (s_last),
        .s_ready_o    (s_ready),
        .lane_data_o  (lane_data),
        .lane_valid_o (lane_valid),
        .busy_o       (busy),
        .tile_done_o  (tile_done),
        .beat_count_o (beat_count),
        .overflow_o   (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int base   = 0;

    bit             acc_h [HMAX];
    bit             last_h[HMAX];
    logic [N*W-1:0] dat_h [HMAX];
    bit             m_in_tile;
    int             m_cnt;
    bit             m_ovf;

    function automatic bit h_acc(int i);
        return (i >= base) ? acc_h[i] : 1'b0;
    endfunction

    function automatic bit h_last(int i);
        return (i >= base) ? last_h[i] : 1'b0;
    endfunction

    // Input is refused for the N cycles that follow an accepted last beat.
    function automatic bit m_ready();
        for (int j = 1; j <= N; j++)
            if (h_last(cyc - j)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit             rdy;
        bit             ev;
        logic [N*W-1:0] row;
        logic [W-1:0]   ed;
        rdy = m_ready();
        chk("s_ready", 64'(s_ready), 64'(rdy));
        chk("busy", 64'(busy), 64'(m_in_tile || !rdy));
        chk("tile_done", 64'(tile_done), 64'(h_last(cyc - N)));
        chk("beat_count", 64'(beat_count), 64'(m_cnt));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("data_known", 64'($isunknown(lane_data)), 64'(0));
        for (int k = 0; k < N; k++) begin
            ev = h_acc(cyc - 1 - k);
            chk($sformatf("lane%0d_valid", k), 64'(lane_valid[k]), 64'(ev));
            if (ev) begin
                row = dat_h[cyc - 1 - k];
                ed  = row[k*W +: W];
                chk($sformatf("lane%0d_data", k), 64'(lane_data[k*W +: W]), 64'(ed));
            end
        end
    endtask

    // One clock cycle: check the outputs, drive the inputs, update the model, advance.
    task automatic step(input bit v, input bit l, input logic [N*W-1:0] d, output bit acc);
        if (cyc >= HMAX - 1) begin
            $display("FAIL history_overflow cycle=%0d", cyc);
            $fatal(1, "history exhausted");
        end
        check_outputs();
        s_valid = v;
        s_last  = l;
        s_data  = d;
        acc = v && m_ready();
        acc_h[cyc]  = acc;
        last_h[cyc] = acc && l;
        dat_h[cyc]  = d;
        if (acc) begin
            if (!m_in_tile) begin
                m_cnt = 1;
                m_ovf = 1'b0;
            end else if (m_cnt == MB) begin
                m_ovf = 1'b1;
            end else begin
                m_cnt++;
            end
            m_in_tile = !l;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'(($urandom & 1)), N*W'($urandom), acc);
    endtask

    // Present a beat and keep it stable until the model says it was taken.
    task automatic send_beat(input logic [N*W-1:0] d, input bit l);
        bit acc;
        int tries;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 20) begin
            step(1'b1, l, d, acc);
            tries++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout cycle=%0d observed=not_accepted expected=accepted", cyc);
        end
    endtask

    function automatic logic [N*W-1:0] dir_data(int b);
        logic [N*W-1:0] d;
        for (int k = 0; k < N; k++) d[k*W +: W] = W'(16'h10 * b + k);
        return d;
    endfunction

    function automatic logic [N*W-1:0] rnd_data();
        logic [N*W-1:0] d;
        for (int k = 0; k < N; k++) d[k*W +: W] = W'($urandom);
        return d;
    endfunction

    task automatic send_tile(input int n, input int bubble_pct, input bit directed);
        bit acc;
        for (int b = 1; b <= n; b++) begin
            if (bubble_pct > 0 && int'($urandom_range(99)) < bubble_pct)
                step(1'b0, 1'(($urandom & 1)), rnd_data(), acc);
            send_beat(directed ? dir_data(b) : rnd_data(), b == n);
        end
    endtask

    task automatic model_reset();
        base = cyc;
        m_in_tile = 1'b0;
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    initial begin
        bit acc;
        rst = 1'b1;
        s_valid = 1'b0;
        s_last = 1'b0;
        s_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_lane_valid", 64'(lane_valid), 64'(0));
        chk("rst_lane_data", 64'(lane_data), 64'(0));
        chk("rst_ready", 64'(s_ready), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(tile_done), 64'(0));
        chk("rst_count", 64'(beat_count), 64'(0));
        rst = 1'b0;
        cyc = 0;
        model_reset();

        // Reset, then idle.
        idle(3);
        // 3-beat directed tile with no gaps.
        send_tile(3, 0, 1'b1);
        idle(6);
        // The same tile with a bubble after beat 1.
        send_beat(dir_data(1), 1'b0);
        step(1'b0, 1'b1, rnd_data(), acc);
        send_beat(dir_data(2), 1'b0);
        send_beat(dir_data(3), 1'b1);
        idle(6);
        // Back-to-back tiles with valid held high between them.
        send_tile(3, 0, 1'b1);
        send_tile(3, 0, 1'b1);
        idle(6);
        // Overflow: 6 beats with MAX_BEATS=4, then a clearing tile.
        send_tile(6, 0, 1'b1);
        idle(6);
        send_tile(2, 0, 1'b1);
        idle(6);
        // Asynchronous reset two beats into a 5-beat tile.
        send_beat(dir_data(1), 1'b0);
        send_beat(dir_data(2), 1'b0);
        s_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("arst_lane_valid", 64'(lane_valid), 64'(0));
        chk("arst_ready", 64'(s_ready), 64'(1));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_done", 64'(tile_done), 64'(0));
        chk("arst_count", 64'(beat_count), 64'(0));
        chk("arst_overflow", 64'(overflow), 64'(0));
        rst = 1'b0;
        model_reset();
        idle(2);
        send_tile(5, 0, 1'b1);
        idle(6);
        // Randomized tiles with random bubbles and gaps.
        for (int t = 0; t < 12; t++) begin
            send_tile(int'($urandom_range(1, 7)), 30, 1'b0);
            idle(int'($urandom_range(0, 3)));
        end
        idle(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
